// File: rtl/chaos_pkg.sv
// rtl/chaos_pkg.sv - shared state encoding and width defaults for the chaotic S-box generator
package chaos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    HARVEST,
    PROBE,
    DONE
  } state_t;

  localparam int SBOX_W_DEFAULT   = 8;
  localparam int FRAC_W_DEFAULT   = 16;
  localparam int R_W_DEFAULT      = 16;
  localparam int WARMUP_N_DEFAULT = 64;

  // r = 0xFFFF in Q2.14 is just under 4.0, the fully chaotic end of the map
  localparam logic [15:0] R_Q_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/logistic_step.sv
// rtl/logistic_step.sv - one combinational fixed-point logistic map step y = r*x*(1-x)
module logistic_step
  import chaos_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEFAULT,
  parameter int R_W    = R_W_DEFAULT
) (
  input  logic [FRAC_W-1:0] x,
  input  logic [R_W-1:0]    r,
  input  logic [FRAC_W-1:0] seed_q,
  output logic [FRAC_W-1:0] y
);

  localparam int PW = 2*FRAC_W + 1;
  localparam int YW = FRAC_W + 1 + R_W;

  logic [FRAC_W:0] om;
  logic [PW-1:0]   xo;
  logic [FRAC_W:0] p;
  logic [YW-1:0]   pr;
  logic [YW-1:0]   ys;

  always_comb begin
    om = {1'b1, {FRAC_W{1'b0}}} - {1'b0, x};
    xo = {{(FRAC_W+1){1'b0}}, x} * {{FRAC_W{1'b0}}, om};
    p  = (FRAC_W+1)'(xo >> FRAC_W);
    pr = {{R_W{1'b0}}, p} * {{(FRAC_W+1){1'b0}}, r};
    ys = pr >> (R_W-2);
    // zero is a fixed point of the map; fall back to the seed to keep iterating
    if (ys[YW-1:FRAC_W] != '0)
      y = '1;
    else if (ys[FRAC_W-1:0] == '0)
      y = seed_q;
    else
      y = ys[FRAC_W-1:0];
  end

endmodule

// File: rtl/chaos_sbox_gen.sv
// rtl/chaos_sbox_gen.sv - key-seeded bijective S-box builder; INV_SBOX_EN adds the inverse table
module chaos_sbox_gen
  import chaos_pkg::*;
#(
  parameter int SBOX_W   = SBOX_W_DEFAULT,
  parameter int FRAC_W   = FRAC_W_DEFAULT,
  parameter int R_W      = R_W_DEFAULT,
  parameter int WARMUP_N = WARMUP_N_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FRAC_W-1:0] seed,
  input  logic [R_W-1:0]    r_param,
  output logic              busy,
  output logic              done_sbox,
  input  logic [SBOX_W-1:0] rd_addr,
`ifdef INV_SBOX_EN
  output logic [SBOX_W-1:0] inv_rd_data,
`endif
  output logic [SBOX_W-1:0] rd_data
);

  localparam int N     = 1 << SBOX_W;
  localparam int CNT_W = $clog2(WARMUP_N + 1);

  state_t state, state_nx;

  logic [FRAC_W-1:0] x, seed_q, fx;
  logic [R_W-1:0]    r_q;
  logic [SBOX_W-1:0] idx, p_cand, cand, wr_val;
  logic [N-1:0]      used;
  logic [CNT_W-1:0]  cnt;
  logic              wr_en;

  logic [SBOX_W-1:0] sbox_mem [N];
`ifdef INV_SBOX_EN
  logic [SBOX_W-1:0] inv_mem [N];
`endif

  logistic_step #(.FRAC_W(FRAC_W), .R_W(R_W)) u_step (
    .x      (x),
    .r      (r_q),
    .seed_q (seed_q),
    .y      (fx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cand     = x[FRAC_W-1 -: SBOX_W];
    wr_en    = 1'b0;
    wr_val   = cand;
    case (state)
      IDLE:    if (start) state_nx = WARMUP;
      WARMUP:  if (cnt == CNT_W'(WARMUP_N - 1)) state_nx = HARVEST;
      HARVEST: begin
        wr_en = !used[cand];
        if (!wr_en)       state_nx = PROBE;
        else if (idx == '1) state_nx = DONE;
      end
      PROBE: begin
        wr_val = p_cand;
        wr_en  = !used[p_cand];
        if (wr_en) state_nx = (idx == '1) ? DONE : HARVEST;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x         <= '0;
      seed_q    <= '0;
      r_q       <= R_W'(R_Q_DEFAULT);
      idx       <= '0;
      p_cand    <= '0;
      used      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done_sbox <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          seed_q    <= seed | FRAC_W'(1);
          r_q       <= r_param;
          x         <= seed | FRAC_W'(1);
          used      <= '0;
          idx       <= '0;
          cnt       <= '0;
          busy      <= 1'b1;
          done_sbox <= 1'b0;
        end
        WARMUP: begin
          x   <= fx;
          cnt <= cnt + 1'b1;
        end
        HARVEST: begin
          x <= fx;
          if (!wr_en) p_cand <= cand + 1'b1;
        end
        PROBE: if (!wr_en) p_cand <= p_cand + 1'b1;
        DONE: begin
          busy      <= 1'b0;
          done_sbox <= 1'b1;
        end
        default: ;
      endcase
      if (wr_en) begin
        used[wr_val] <= 1'b1;
        idx          <= idx + 1'b1;
      end
    end
  end

  // table storage is deliberately unreset; the used bitmap alone tracks validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sbox_mem[idx] <= wr_val;
`ifdef INV_SBOX_EN
      inv_mem[wr_val] <= idx;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
`ifdef INV_SBOX_EN
      inv_rd_data <= '0;
`endif
    end else begin
      rd_data <= done_sbox ? sbox_mem[rd_addr] : '0;
`ifdef INV_SBOX_EN
      inv_rd_data <= done_sbox ? inv_mem[rd_addr] : '0;
`endif
    end
  end

endmodule

// File: doc/chaos_sbox_gen.md
Name: chaos_sbox_gen

Overview:
- Parametrised successor to the fixed 8-bit chaotic S-box stage that drives done_sbox in top.
- Iterates a fixed-point logistic map from a key-derived seed and builds a bijective 2^SBOX_W-entry S-box.
- Collisions are resolved by linear probing, so generation always terminates.
- Exposes a registered lookup port for the pixel-diffusion datapath, plus an optional inverse table for decryption.

Parameters:
- SBOX_W, 8: symbol width; the table has 2^SBOX_W entries.
- FRAC_W, 16: fraction bits of map state x (Q0.FRAC_W unsigned).
- R_W, 16: width of control parameter r (Q2.(R_W-2)).
- WARMUP_N, 64: map iterations discarded before harvesting.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle request to begin generation.
- seed, in, FRAC_W: initial x, sampled on accepted start.
- r_param, in, R_W: map parameter, sampled on accepted start.
- busy, out, 1: high from accepted start until done.
- done_sbox, out, 1: level; high when the table is complete, until the next accepted start.
- rd_addr, in, SBOX_W: lookup address.
- rd_data, out, SBOX_W: sbox[rd_addr], one-cycle registered.
- inv_rd_data, out, SBOX_W: inverse lookup; present only with INV_SBOX_EN.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, done_sbox=0, rd_data=0, inv_rd_data=0.
  - x=0, idx=0, used bitmap cleared.
  - Table contents are undefined after reset.
- Map step f(x), in this order:
  - om = 2^FRAC_W - x (FRAC_W+1 bits).
  - p = (x*om) >> FRAC_W.
  - y = (p*r) >> (R_W-2).
  - If y ≥ 2^FRAC_W, saturate y to 2^FRAC_W-1.
  - If y == 0, substitute seed_q (this escapes the fixed point).
- seed_q: latched seed with bit0 forced to 1, so a seed of 0 becomes 1.
- cand = x[FRAC_W-1 -: SBOX_W], i.e. the top SBOX_W bits of the current x.
- IDLE:
  - On start: latch seed_q and r_q, set x=seed_q, clear used, idx=0, cnt=0.
  - Next cycle: busy=1, done_sbox=0 → WARMUP.
- WARMUP:
  - Each cycle: x<=f(x), cnt++.
  - After WARMUP_N iterations → HARVEST.
- HARVEST, one map step per cycle (x<=f(x)):
  - If used[cand]==0: write sbox[idx]=cand (and inv[cand]=idx), set used[cand], then idx++.
  - Otherwise: p_cand<=cand+1 (mod 2^SBOX_W) → PROBE.
- PROBE, x held:
  - If used[p_cand]==0: write it at idx as above → HARVEST.
  - Otherwise: p_cand++ with wrap, stay in PROBE.
- Completion:
  - The write with idx == 2^SBOX_W-1 → DONE.
  - Next cycle: busy=0, done_sbox=1 → IDLE.
  - Total cycles ≤ WARMUP_N + 2^SBOX_W·(2^SBOX_W+1) + 2.
- Start handling:
  - start while busy is ignored.
  - start while done_sbox=1 restarts and drops done_sbox.
- Lookup port:
  - rd_data <= done_sbox ? sbox[rd_addr] : 0, registered.
  - Reads during generation return 0.
- Reset mid-operation aborts immediately; the next start regenerates from scratch.

Optional Feature:
- INV_SBOX_EN defined:
  - A second 2^SBOX_W×SBOX_W table inv is written in parallel (inv[value]=idx).
  - inv_rd_data <= done_sbox ? inv[rd_addr] : 0, with the same latency as rd_data.
- Not defined: port inv_rd_data and the inv table are absent.

Decomposition:
- Package chaos_pkg holds:
  - state encoding (IDLE, WARMUP, HARVEST, PROBE, DONE);
  - the default R_Q constant 16'hFFFF (≈3.99994);
  - the f(x) width constants.
- Sub-module logistic_step: purely combinational f(x, r) with saturation and zero-substitution; reused by the key-stream generator.

Test Plan:
- Reset values: hold rst=0 for 20 ns with random inputs → busy=0, done_sbox=0, rd_data=0. Release rst; no activity until start.
- Bijectivity: seed=16'h3A5C, r=16'hFFFF. Completion within the bound → read all 256 addresses; values are distinct and cover 0..255. Repeating with the same seed gives an identical table.
- Zero seed: seed=0 → generation completes and the table is a permutation; the result equals the table for seed=16'h0001.
- Restart and ignored start:
  - start pulsed mid-HARVEST → ignored, busy stays 1, and the table equals that of an uninterrupted run.
  - start after done_sbox with seed=16'h1234 → done_sbox drops next cycle, then the new table differs.
- Reset mid-operation: rst=0 during PROBE → all outputs return to reset values asynchronously; a fresh start then yields the same table as a clean run.
- INV_SBOX_EN: for all i, inv[sbox[i]]==i. rd_data and inv_rd_data update exactly one clk after rd_addr changes.
